// File: rtl/sync_fifo_fwft_pkg.sv
// ============================================================================
// Module   : sync_fifo_fwft_pkg
// Brief    : Shared widths and depth derivation for the handshake FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_fifo_fwft_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dpram_simple.sv
// ============================================================================
// Module   : dpram_simple
// Brief    : Simple dual-port RAM, registered read, returns old data on a
//            same-address read/write collision. Port A writes, port B r/w.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram_simple #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic                  wren_a,
  input  logic [DATA_WIDTH-1:0] wrdata_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic                  wren_b,
  input  logic [DATA_WIDTH-1:0] wrdata_b,
  output logic [DATA_WIDTH-1:0] rddata_b
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wren_a) mem[addr_a] <= wrdata_a;
    if (wren_b) mem[addr_b] <= wrdata_b;
    rddata_b <= mem[addr_b];
  end

endmodule

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
// ============================================================================
// Module   : sync_fifo_fwft
// Brief    : First-word-fall-through FIFO over dpram_simple with valid/ready
//            handshakes on both sides and a one-entry output skid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_fwft
  import sync_fifo_fwft_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int                CW        = ADDR_WIDTH + 1;
  localparam int                DEPTH     = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d, ram_cnt_q, ram_cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  fetch_q, fetch_d;
  logic                  head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  push, pop, fetch;
  logic [1:0]            stage_words;

  dpram_simple #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk      (clock),
    .addr_a   (wr_ptr_q),
    .wren_a   (push),
    .wrdata_a (in_data),
    .addr_b   (rd_ptr_q),
    .wren_b   (1'b0),
    .wrdata_b ({DATA_WIDTH{1'b0}}),
    .rddata_b (rd_data)
  );

  // The head is either a held register or the word the RAM returned this cycle.
  assign out_valid = head_valid_q | fetch_q;
  assign out_data  = head_valid_q ? head_data_q : (fetch_q ? rd_data : '0);
  assign in_ready  = in_ready_q;
  assign count     = count_q;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid & out_ready;

  // Words held past this edge plus a new fetch must fit in head + skid.
  assign stage_words = 2'(head_valid_q) + 2'(skid_valid_q) + 2'(fetch_q);
  assign fetch = (ram_cnt_q != '0) && ((stage_words - 2'(pop)) <= 2'd1);

  always_comb begin
    wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(fetch);
    count_d      = count_q + CW'(push) - CW'(pop);
    ram_cnt_d    = ram_cnt_q + CW'(push) - CW'(fetch);
    in_ready_d   = (count_d != DEPTH_CNT);
    fetch_d      = fetch;
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (pop && head_valid_q) begin
      if (skid_valid_q) begin
        head_data_d = skid_data_q;
        if (fetch_q) skid_data_d = rd_data;
        else         skid_valid_d = 1'b0;
      end else if (fetch_q) begin
        head_data_d = rd_data;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (!pop && fetch_q) begin
      // Capture the returned word so it stays stable under back-pressure.
      if (head_valid_q) begin
        skid_valid_d = 1'b1;
        skid_data_d  = rd_data;
      end else begin
        head_valid_d = 1'b1;
        head_data_d  = rd_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ram_cnt_q    <= '0;
      in_ready_q   <= 1'b1;
      fetch_q      <= 1'b0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ram_cnt_q    <= ram_cnt_d;
      in_ready_q   <= in_ready_d;
      fetch_q      <= fetch_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_fwft.sv
// ============================================================================
// Module   : tb_sync_fifo_fwft
// Brief    : Self-checking bench for sync_fifo_fwft against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_fwft;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [AW:0]   count;

  int checks;
  int failures;
  logic [DW-1:0] exp_q[$];

  always #5 clock = ~clock;

  sync_fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  // Advance one edge and apply the FIFO rules to the reference queue.
  task automatic tick();
    bit can_push;
    if (rst) begin
      exp_q.delete();
    end else begin
      can_push = (exp_q.size() != DEPTH);
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && can_push) exp_q.push_back(in_data);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (count !== '0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
  endtask

  task automatic test_latency();
    in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL lat_count1: got %0d expected 1", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_valid1: got %b expected 0", out_valid); end
    tick();
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL lat_count2: got %0d expected 1", count); end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001) begin
      failures++; $display("FAIL lat_out: got valid=%b data=%h expected valid=1 data=a5a50001", out_valid, out_data);
    end
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL lat_after_pop: got count=%0d valid=%b expected 0/0", count, out_valid);
    end
  endtask

  task automatic test_fill_full_drain();
    int cyc;
    logic [DW-1:0] next_exp;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      tick();
    end
    checks++; if (in_ready !== 1'b0 || count !== 5'd16) begin
      failures++; $display("FAIL fill_full: got in_ready=%b count=%0d expected 0/16", in_ready, count);
    end
    in_data = 32'hBAD0_0017;
    tick();
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL fill_17th: got count=%0d expected 16", count); end
    // Push and pop together while full: only the pop takes effect.
    in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd0) begin
      failures++; $display("FAIL full_head: got valid=%b data=%h expected 1/0", out_valid, out_data);
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 5'd15 || in_ready !== 1'b1) begin
      failures++; $display("FAIL full_pushpop: got count=%0d in_ready=%b expected 15/1", count, in_ready);
    end
    out_ready = 1'b1;
    next_exp = 32'd1;
    cyc = 0;
    while (next_exp != 32'd16 && cyc < 100) begin
      if (out_valid) begin
        checks++; if (out_data !== next_exp) begin
          failures++; $display("FAIL drain_order: got %h expected %h", out_data, next_exp);
        end
        next_exp = next_exp + 32'd1;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    checks++; if (next_exp != 32'd16 || out_valid !== 1'b0 || count !== '0) begin
      failures++; $display("FAIL drain_end: got next=%0d valid=%b count=%0d expected 16/0/0", next_exp, out_valid, count);
    end
  endtask

  task automatic test_stream();
    int cyc;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (k >= 2) begin
        checks++; if (out_valid !== 1'b1 || out_data !== DW'(k - 2)) begin
          failures++; $display("FAIL stream_word: cycle %0d got valid=%b data=%h expected 1/%h", k, out_valid, out_data, DW'(k - 2));
        end
      end
      checks++; if (count > 5'd2) begin failures++; $display("FAIL stream_count: got %0d expected <=2", count); end
      in_data = DW'(k);
      tick();
    end
    in_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 50) begin
      if (out_valid) begin
        checks++; if (out_data !== exp_q[0]) begin
          failures++; $display("FAIL stream_tail: got %h expected %h", out_data, exp_q[0]);
        end
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    checks++; if (exp_q.size() != 0 || count !== '0) begin
      failures++; $display("FAIL stream_drain: got left=%0d count=%0d expected 0/0", exp_q.size(), count);
    end
  endtask

  task automatic test_random();
    int pushed;
    logic hold_prev;
    logic [DW-1:0] data_prev;
    pushed = 0;
    hold_prev = 1'b0;
    data_prev = '0;
    for (int cyc = 0; cyc < 20000 && (pushed < 1000 || exp_q.size() > 0); cyc++) begin
      checks++; if (count !== (AW+1)'(exp_q.size())) begin
        failures++; $display("FAIL rnd_count: got %0d expected %0d", count, exp_q.size());
      end
      checks++; if (in_ready !== (exp_q.size() != DEPTH)) begin
        failures++; $display("FAIL rnd_in_ready: got %b expected %b", in_ready, exp_q.size() != DEPTH);
      end
      if (hold_prev) begin
        checks++; if (out_valid !== 1'b1 || out_data !== data_prev) begin
          failures++; $display("FAIL rnd_stable: got valid=%b data=%h expected 1/%h", out_valid, out_data, data_prev);
        end
      end
      if (out_valid) begin
        checks++; if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
          failures++; $display("FAIL rnd_data: got %h expected %h (model size %0d)", out_data,
                               (exp_q.size() > 0) ? exp_q[0] : 32'h0, exp_q.size());
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (pushed < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = $urandom;
      if (in_valid && exp_q.size() != DEPTH) pushed++;
      hold_prev = out_valid && !out_ready;
      data_prev = out_data;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (pushed < 1000 || exp_q.size() != 0) begin
      failures++; $display("FAIL rnd_timeout: got pushed=%0d left=%0d expected 1000/0", pushed, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 32'h7700_0000 + DW'(i);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (count !== 5'd7) begin failures++; $display("FAIL mid_count7: got %0d expected 7", count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || count !== '0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL mid_reset: got valid=%b count=%0d in_ready=%b expected 0/0/1", out_valid, count, in_ready);
    end
    in_valid = 1'b1; in_data = 32'h0000_1234; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_early: got valid=%b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_1234) begin
      failures++; $display("FAIL mid_first: got valid=%b data=%h expected 1/00001234", out_valid, out_data);
    end
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || count !== '0) begin
      failures++; $display("FAIL mid_empty: got valid=%b count=%0d expected 0/0", out_valid, count);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    test_reset();
    test_latency();
    test_fill_full_drain();
    test_stream();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
